// File: rtl/rle_pkg.sv
// rle_pkg: shared record widths, record field helpers and control-state encoding
// for the run-length record arbiter.
package rle_pkg;
    localparam int STR_W = 128;
    localparam int CNT_W = 32;
    localparam int REC_W = STR_W + CNT_W;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    function automatic logic [STR_W-1:0] rec_str(input logic [REC_W-1:0] r);
        return r[REC_W-1:CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] rec_cnt(input logic [REC_W-1:0] r);
        return r[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/rle_record_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; grants the first requester at or
// above ptr, wrapping around to lane 0.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] j;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
        if (any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/rle_record_arbiter.sv
// rle_record_arbiter: merges per-lane {string,count} records onto one valid/ready
// stream, drops zero-count records, and supports a flush-and-report drain.
module rle_record_arbiter
    import rle_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int STR_W     = rle_pkg::STR_W,
    parameter int CNT_W     = rle_pkg::CNT_W,
    parameter int REC_W     = STR_W + CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LANES-1:0]         lane_valid,
    input  logic [NUM_LANES*REC_W-1:0]   lane_rec,
    output logic [NUM_LANES-1:0]         lane_ready,
    output logic                         out_valid,
    output logic [REC_W-1:0]             out_rec,
    output logic [$clog2(NUM_LANES)-1:0] out_lane,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [15:0]                  drop_count
);
    localparam int LW = $clog2(NUM_LANES);

    state_t               state;
    logic [NUM_LANES-1:0] held, grant, take, acc;
    logic [REC_W-1:0]     held_rec [NUM_LANES];
    logic [LW-1:0]        rr_ptr, g_idx;
    logic                 g_any, free, load;
    logic [3:0]           n_drop;
    logic [16:0]          drop_sum;

    rr_arbiter #(.N(NUM_LANES), .W(LW)) u_arb (
        .req   (held),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (g_idx),
        .any   (g_any)
    );

    assign free       = !out_valid | out_ready;
    assign load       = free & g_any;
    assign take       = load ? grant : '0;
    assign lane_ready = (state == RUN) ? (~held | take) : '0;
    assign acc        = lane_valid & lane_ready;

    // Several lanes may drop a zero-count record on the same edge.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_LANES; i++)
            n_drop = n_drop + 4'(acc[i] && lane_rec[i*REC_W +: CNT_W] == '0);
        drop_sum = {1'b0, drop_count} + 17'(n_drop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            held       <= '0;
            out_valid  <= 1'b0;
            out_rec    <= '0;
            out_lane   <= '0;
            rr_ptr     <= '0;
            flush_done <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < NUM_LANES; i++) held_rec[i] <= '0;
        end else begin
            // A refill on the take edge overrides the clear, so a lane streams 1/cycle.
            for (int i = 0; i < NUM_LANES; i++) begin
                if (acc[i] && lane_rec[i*REC_W +: CNT_W] != '0) begin
                    held[i]     <= 1'b1;
                    held_rec[i] <= lane_rec[i*REC_W +: REC_W];
                end else if (take[i]) begin
                    held[i] <= 1'b0;
                end
            end
            if (free) begin
                out_valid <= g_any;
                if (g_any) begin
                    out_rec  <= held_rec[g_idx];
                    out_lane <= g_idx;
                    rr_ptr   <= (int'(g_idx) == NUM_LANES - 1) ? '0 : g_idx + 1'b1;
                end
            end
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            flush_done <= 1'b0;
            case (state)
                RUN:   if (flush) state <= DRAIN;
                DRAIN: if (held == '0 && free) begin
                    state      <= DONE;
                    flush_done <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_rle_record_arbiter.sv
// tb_rle_record_arbiter: randomized and directed stimulus with a per-lane FIFO
// scoreboard and a saturating drop counter model.
`timescale 1ns/1ps
module tb_rle_record_arbiter;
    localparam int NL = 4, RW = 160, CW = 32, DEPTH = 16;
    typedef struct packed { logic [1:0] lane; logic [RW-1:0] rec; } ent_t;

    logic            clk = 1'b0, reset = 1'b1;
    logic [NL-1:0]   lane_valid = '0, lane_ready;
    logic [NL*RW-1:0] lane_rec = '0;
    logic            out_valid, out_ready = 1'b1, flush = 1'b0, flush_done;
    logic [RW-1:0]   out_rec;
    logic [1:0]      out_lane;
    logic [15:0]     drop_count;

    rle_record_arbiter #(.NUM_LANES(NL)) dut (
        .clk(clk), .reset(reset), .lane_valid(lane_valid), .lane_rec(lane_rec),
        .lane_ready(lane_ready), .out_valid(out_valid), .out_rec(out_rec),
        .out_lane(out_lane), .out_ready(out_ready), .flush(flush),
        .flush_done(flush_done), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    logic [RW-1:0] src [NL][DEPTH];
    int            head [NL];
    int            tail [NL];
    ent_t          sb[$];
    logic [1:0]    got[$];
    ent_t          e_new;
    int            nvec = 0, nerr = 0, exp_drop = 0, rdy_mode = 0;
    logic          stall_prev = 1'b0;
    logic [RW-1:0] prev_rec;
    logic [1:0]    prev_lane;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [RW-1:0] rnd_rec(input logic [CW-1:0] cnt);
        return {$urandom, $urandom, $urandom, $urandom, cnt};
    endfunction

    function automatic bit idle();
        for (int i = 0; i < NL; i++) if (head[i] != tail[i]) return 1'b0;
        return sb.size() == 0 && !out_valid;
    endfunction

    task automatic push(input int l, input logic [RW-1:0] r);
        while (tail[l] - head[l] >= DEPTH) @(posedge clk);
        src[l][tail[l] % DEPTH] = r;
        tail[l]++;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (n < budget && !idle()) begin
            @(negedge clk);
            n++;
        end
        chk(name, RW'(idle()), RW'(1));
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2;
        reset = 1'b1;
        lane_valid = '0;
        flush = 1'b0;
        for (int i = 0; i < NL; i++) head[i] = tail[i];
        sb.delete();
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // Driver: present the head of each lane's source queue, shape out_ready.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            lane_valid[i] = !reset && head[i] != tail[i] && (rdy_mode != 3 || $urandom_range(0, 3) != 0);
            lane_rec[i*RW +: RW] = src[i][head[i] % DEPTH];
        end
        out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 :
                    rdy_mode == 2 ? ~out_ready : 1'($urandom_range(0, 1));
    end

    // Acceptance side: nonzero records become expectations, zero ones bump the drop model.
    always @(negedge clk) if (!reset) begin
        for (int i = 0; i < NL; i++) if (lane_valid[i] && lane_ready[i]) begin
            if (lane_rec[i*RW +: CW] == '0) begin
                if (exp_drop < 65535) exp_drop = exp_drop + 1;
            end else begin
                e_new.lane = 2'(i);
                e_new.rec  = lane_rec[i*RW +: RW];
                sb.push_back(e_new);
            end
            head[i]++;
        end
    end

    // Monitor: each lane's records must emerge in order; a stalled output must hold.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", RW'(out_valid), RW'(1));
                chk("stall_rec", out_rec, prev_rec);
                chk("stall_lane", RW'(out_lane), RW'(prev_lane));
            end
            if (out_valid && out_ready) begin
                int f = -1;
                for (int i = 0; i < sb.size(); i++) if (sb[i].lane == out_lane) begin
                    f = i;
                    break;
                end
                if (f < 0) begin
                    chk("unexpected_out", RW'(out_lane) + RW'(1), RW'(0));
                end else begin
                    chk("out_rec", out_rec, sb[f].rec);
                    sb.delete(f);
                end
                got.push_back(out_lane);
            end
            stall_prev = out_valid && !out_ready;
            prev_rec   = out_rec;
            prev_lane  = out_lane;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] r1a, r2a;
        int pulses, outs_at_done, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", RW'(out_valid), RW'(0));
        chk("rst_out_rec", out_rec, RW'(0));
        chk("rst_out_lane", RW'(out_lane), RW'(0));
        chk("rst_flush_done", RW'(flush_done), RW'(0));
        chk("rst_drop", RW'(drop_count), RW'(0));
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_lane_ready", RW'(lane_ready), RW'(4'hF));

        // Single record on lane 0: visible after the edge following acceptance.
        push(0, {{32{4'hA}}, 32'd5});
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lat_early", RW'(out_valid), RW'(0));
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", RW'(out_valid), RW'(1));
        chk("lat_rec", out_rec, {{32{4'hA}}, 32'd5});
        chk("lat_lane", RW'(out_lane), RW'(0));
        wait_idle("single_drain", 20);

        // All lanes busy: strict rotation 0,1,2,3,0,1,2,3.
        reset_dut();
        got.delete();
        for (int k = 0; k < 2; k++) for (int i = 0; i < NL; i++) push(i, rnd_rec($urandom | 1));
        wait_idle("rr_drain", 60);
        chk("rr_count", RW'(got.size()), RW'(8));
        for (int k = 0; k < got.size() && k < 8; k++) chk("rr_order", RW'(got[k]), RW'(k % 4));

        // Stall with lanes 1 and 2 pending, then release: 1,2,1,2.
        got.delete();
        rdy_mode = 1;
        r1a = rnd_rec($urandom | 1);
        r2a = rnd_rec($urandom | 1);
        push(1, r1a);
        push(1, rnd_rec($urandom | 1));
        push(2, r2a);
        push(2, rnd_rec($urandom | 1));
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("stall_out_valid", RW'(out_valid), RW'(1));
        chk("stall_out_rec", out_rec, r1a);
        chk("stall_out_lane", RW'(out_lane), RW'(1));
        chk("stall_ready_1", RW'(lane_ready[1]), RW'(0));
        chk("stall_ready_2", RW'(lane_ready[2]), RW'(0));
        #2 rdy_mode = 0;
        wait_idle("stall_drain", 40);
        chk("stall_count", RW'(got.size()), RW'(4));
        for (int k = 0; k < got.size() && k < 4; k++) chk("stall_order", RW'(got[k]), RW'(k % 2 + 1));

        // Zero-count drops and saturation.
        got.delete();
        for (int k = 0; k < 3; k++) push(3, rnd_rec(32'd0));
        wait_idle("drop_drain", 20);
        chk("drop_3", RW'(drop_count), RW'(3));
        chk("drop_no_out", RW'(got.size()), RW'(0));
        for (int k = 0; k < 16382; k++) for (int i = 0; i < NL; i++) push(i, rnd_rec(32'd0));
        wait_idle("preload_drain", 100);
        chk("drop_preload", RW'(drop_count), RW'(16'hFFFB));
        for (int k = 0; k < 3; k++) push(3, rnd_rec(32'd0));
        wait_idle("drop_near_drain", 20);
        chk("drop_near", RW'(drop_count), RW'(16'hFFFE));
        for (int k = 0; k < 3; k++) push(3, rnd_rec(32'd0));
        wait_idle("drop_sat_drain", 20);
        chk("drop_sat", RW'(drop_count), RW'(16'hFFFF));
        chk("drop_model", RW'(drop_count), RW'(exp_drop));

        // Flush with three lanes pending and out_ready toggling.
        got.delete();
        rdy_mode = 1;
        push(0, rnd_rec($urandom | 1));
        push(2, rnd_rec($urandom | 1));
        push(3, rnd_rec($urandom | 1));
        n = 0;
        while (n < 20 && !(head[0] == tail[0] && head[2] == tail[2] && head[3] == tail[3])) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #2 flush = 1'b1;
        rdy_mode = 2;
        @(posedge clk);
        #2 flush = 1'b0;
        pulses = 0;
        outs_at_done = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (flush_done) begin
                pulses++;
                if (outs_at_done < 0) outs_at_done = got.size();
            end else if (pulses == 0) begin
                chk("drain_lane_ready", RW'(lane_ready), RW'(0));
            end
            flush = (c == 1);
        end
        flush = 1'b0;
        rdy_mode = 0;
        chk("flush_pulses", RW'(pulses), RW'(1));
        chk("flush_outs", RW'(outs_at_done), RW'(3));
        @(negedge clk);
        chk("flush_ready_back", RW'(lane_ready), RW'(4'hF));

        // Flush with nothing pending: done pulse in the cycle after edge k+1.
        @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_k", RW'(flush_done), RW'(0));
        chk("idle_flush_drain_ready", RW'(lane_ready), RW'(0));
        @(negedge clk);
        chk("idle_flush_k1", RW'(flush_done), RW'(1));
        @(negedge clk);
        chk("idle_flush_k2", RW'(flush_done), RW'(0));
        chk("idle_flush_ready", RW'(lane_ready), RW'(4'hF));

        // Randomized traffic with random backpressure and gaps.
        reset_dut();
        rdy_mode = 3;
        for (int k = 0; k < 300; k++)
            push($urandom_range(0, NL - 1), rnd_rec($urandom_range(0, 4) == 0 ? 32'd0 : ($urandom | 1)));
        rdy_mode = 0;
        wait_idle("rand_drain", 3000);
        chk("rand_drop", RW'(drop_count), RW'(exp_drop));

        // Reset while an output is valid and two records are held.
        @(posedge clk);
        #2 rdy_mode = 1;
        push(0, rnd_rec($urandom | 1));
        push(1, rnd_rec($urandom | 1));
        push(2, rnd_rec($urandom | 1));
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_valid", RW'(out_valid), RW'(1));
        reset = 1'b1;
        lane_valid = '0;
        for (int i = 0; i < NL; i++) head[i] = tail[i];
        sb.delete();
        exp_drop = 0;
        #1;
        chk("async_reset_valid", RW'(out_valid), RW'(0));
        chk("async_reset_done", RW'(flush_done), RW'(0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        rdy_mode = 0;
        got.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_reset_no_out", RW'(got.size()), RW'(0));
        chk("post_reset_valid", RW'(out_valid), RW'(0));
        chk("post_reset_drop", RW'(drop_count), RW'(0));
        push(1, rnd_rec($urandom | 1));
        push(0, rnd_rec($urandom | 1));
        wait_idle("tie_drain", 20);
        chk("tie_count", RW'(got.size()), RW'(2));
        if (got.size() > 0) chk("tie_first", RW'(got[0]), RW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/rle_record_arbiter.md
# rle_record_arbiter

Round-robin arbiter that merges the `{string, count}` run-length records from NUM_LANES parallel string-counter lanes onto one valid/ready output stream for the compressed-genome writer. Each lane gets a one-record holding register. Zero-count records are dropped and counted. A flush command drains every held record and then signals completion, so software can close a compressed block cleanly.

## Interface
Parameters:
- NUM_LANES, 4: number of counter lanes (2..8)
- STR_W, 128: string field width
- CNT_W, 32: count field width
- REC_W, STR_W+CNT_W: record width; record layout is `{string[REC_W-1:CNT_W], count[CNT_W-1:0]}`

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- lane_valid  in  NUM_LANES  per-lane record strobe
- lane_rec  in  NUM_LANES*REC_W  lane i record at `[i*REC_W +: REC_W]`
- lane_ready  out  NUM_LANES  lane i record accepted on an edge where `lane_valid[i] & lane_ready[i]`
- out_valid  out  1  output record valid
- out_rec  out  REC_W  output record
- out_lane  out  $clog2(NUM_LANES)  source lane of out_rec
- out_ready  in  1  downstream accepts on an edge where `out_valid & out_ready`
- flush  in  1  single-cycle drain request
- flush_done  out  1  one-cycle pulse after drain completes
- drop_count  out  16  zero-count records discarded; saturates at 0xFFFF

## Operation
- Holding register per lane: `held[i]` flag plus record.
  - `lane_ready[i] = (state==RUN) & (!held[i] | take[i])`.
  - `take[i]` = lane i granted this cycle and the output register loads.
- An accepted record with count==0 is never held. It increments drop_count instead.
- Output register loads when `!out_valid | out_ready` (the output is free). It then loads the record of the granted lane.
- out_rec and out_lane hold stable while `out_valid & !out_ready`.
- Arbiter:
  - Grants among lanes with `held` set, searching upward from `rr_ptr`.
  - After a load, `rr_ptr` = granted lane + 1, mod NUM_LANES.
  - With no load, `rr_ptr` does not change.
- State machine:
  - RUN: normal operation. flush moves to DRAIN.
  - DRAIN: all lane_ready=0. Move to DONE when all `held` flags are clear and (`!out_valid`, or `out_valid & out_ready` this cycle).
  - DONE: flush_done=1 for exactly one cycle, then RUN.
- flush in DRAIN or DONE is ignored.
- Reset values:
  - all `held`=0; out_valid=0, out_rec=0, out_lane=0
  - rr_ptr=0, state RUN, flush_done=0, drop_count=0
  - lane_ready is combinational: all 1 once reset is released.
- Reset mid-operation discards all held and output records immediately. No flush_done is issued.

## Timing
- Latency: a record accepted at edge k is at the earliest valid on out_rec after edge k+1.
- Throughput: one record per cycle in aggregate while out_ready=1. A single lane also sustains 1/cycle, because a held slot refills on the same edge its record is taken.
- All outputs are registered except lane_ready.
- Simultaneous lane-accept and output-take on the same lane: the new record replaces the taken one in the holding register, with no bubble.
- Zero-count drop and drop_count increment take effect on the acceptance edge.
- flush arriving on a cycle when lanes are valid: those lanes still accept on that edge, because the state is RUN during that cycle. The accepted records are drained.
- Drain with nothing pending: flush at edge k puts the block in DRAIN after k. It enters DONE after k+1, with flush_done high in the cycle after edge k+1.

## Structure
- Package `rle_pkg` holds:
  - STR_W, CNT_W, REC_W constants
  - record field slicing functions
  - the state encoding (RUN, DRAIN, DONE)
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs: request vector, rr_ptr
  - outputs: one-hot grant, encoded index, any-grant
  - purely combinational; the pointer register stays in the parent

## Test plan
- Single lane 0 sends `{0xA..A, 5}` with out_ready=1 → out_valid is high after the next edge, with out_rec=`{0xA..A,5}` and out_lane=0.
- All four lanes valid for 8 cycles, out_ready=1 → output lanes run 0,1,2,3,0,1,2,3. lane_ready stays 1 throughout and no record is lost.
- out_ready=0 for 5 cycles with lanes 1 and 2 pending → out_rec stays stable and lane_ready[1]=lane_ready[2]=0 after their second record. On release, lanes drain in the order 1,2,1,2.
- Lane 3 sends count=0 three times → no output, drop_count=3. Pre-load drop_count near 0xFFFF and send 3 more → it saturates at 0xFFFF.
- Records pending in 3 lanes, pulse flush, out_ready toggling 1/0 → all lane_ready=0 in DRAIN, all 3 records are output, then a single flush_done pulse, then lane_ready returns.
- Assert reset while out_valid=1 and 2 records are held → out_valid=0 immediately. After release, no stale record appears, rr_ptr=0 (lane 0 wins a 0/1 tie), and drop_count=0.
